// File: rtl/mvm_uart_pkg.sv
// Shared definitions for the matrix-vector / UART datapath blocks:
// FSM state encoding, byte width, and frame-size arithmetic.
package mvm_uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int BYTE_W = 8;

  // Number of data bytes needed to carry r elements of w_y_out bits each.
  function automatic int n_data_f(input int r, input int w_y_out);
    return (r * w_y_out) / BYTE_W;
  endfunction

endpackage

// File: rtl/y_sext_pack.sv
// Purely combinational: widens each of R signed W_Y-bit elements to W_Y_OUT
// bits by sign extension and packs them into one flat frame. Element r
// lands in frame bits [W_Y_OUT*(r+1)-1 : W_Y_OUT*r].
module y_sext_pack #(
  parameter int R       = 8,
  parameter int W_Y     = 19,
  parameter int W_Y_OUT = 32
) (
  input  logic [R*W_Y-1:0]     y,
  output logic [R*W_Y_OUT-1:0] frame
);

  for (genvar r = 0; r < R; r++) begin : g_elem
    // The signed size cast replicates the element's MSB into the upper bits.
    assign frame[W_Y_OUT*r +: W_Y_OUT] = W_Y_OUT'($signed(y[W_Y*r +: W_Y]));
  end

endmodule

// File: rtl/axis_y_byte_serializer.sv
// Serialises one wide result word (R signed W_Y-bit elements) into a byte
// stream: each element is sign-extended to W_Y_OUT bits, bytes go out
// LSB first, element 0 first, tlast on the final byte of the frame.
//
// Optional feature macro: Y_CHECKSUM_EN -- appends one XOR checksum byte
// after the data bytes and moves tlast onto it.
//
// Handshake: a transfer happens on a rising clk edge where tvalid and tready
// are both 1. The input side accepts only in IDLE; the output side presents
// a byte only in SEND and holds tdata/tlast stable while tready is 0.
// s_axis_y_tready is a pure function of the state register, so it never
// depends combinationally on m_axis_b_tready.
module axis_y_byte_serializer
  import mvm_uart_pkg::*;
#(
  parameter int R             = 8,
  parameter int W_Y           = 19,
  parameter int W_Y_OUT       = 32,
  parameter int BITS_PER_WORD = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_axis_y_tvalid,
  output logic               s_axis_y_tready,
  input  logic [R*W_Y-1:0]   s_axis_y_tdata,
  output logic               m_axis_b_tvalid,
  input  logic               m_axis_b_tready,
  output logic [7:0]         m_axis_b_tdata,
  output logic               m_axis_b_tlast
);

  if (BITS_PER_WORD != BYTE_W) begin : g_bad_byte_width
    $error("axis_y_byte_serializer: BITS_PER_WORD must be 8");
  end

  localparam int N_DATA = n_data_f(R, W_Y_OUT);
`ifdef Y_CHECKSUM_EN
  localparam int N_BYTES = N_DATA + 1;
`else
  localparam int N_BYTES = N_DATA;
`endif
  localparam int KW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int FW = R * W_Y_OUT;
  localparam logic [KW-1:0] K_LAST = KW'(N_BYTES - 1);

  state_t          state, state_nx;
  logic [KW-1:0]   k_q;
  logic [FW-1:0]   frame_q;
  logic [FW-1:0]   frame_sh;
  logic [FW-1:0]   sext_frame;
  logic [7:0]      data_q;
  logic [7:0]      next_byte;
  logic            last_q;
  logic            in_hs;
  logic            out_hs;
  logic [KW-1:0]   k_inc;

  y_sext_pack #(
    .R       (R),
    .W_Y     (W_Y),
    .W_Y_OUT (W_Y_OUT)
  ) u_sext (
    .y     (s_axis_y_tdata),
    .frame (sext_frame)
  );

  assign in_hs    = (state == IDLE) && s_axis_y_tvalid;
  assign out_hs   = (state == SEND) && m_axis_b_tready;
  assign k_inc    = k_q + KW'(1);
  assign frame_sh = frame_q >> BYTE_W;

`ifdef Y_CHECKSUM_EN
  localparam logic [KW-1:0] K_LAST_DATA = KW'(N_DATA - 1);
  logic [7:0] csum_q;

  // XOR of every data byte handshaken so far in the current frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csum_q <= '0;
    end else if (in_hs) begin
      csum_q <= '0;
    end else if (out_hs && (k_q <= K_LAST_DATA)) begin
      csum_q <= csum_q ^ data_q;
    end
  end

  // After the last data byte the checksum follows; it must include that byte.
  always_comb begin
    next_byte = frame_sh[7:0];
    if (k_q == K_LAST_DATA) begin
      next_byte = csum_q ^ data_q;
    end
  end
`else
  // Without the checksum the next byte is simply the next frame byte.
  always_comb begin
    next_byte = frame_sh[7:0];
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_nx        = state;
    s_axis_y_tready = 1'b0;
    m_axis_b_tvalid = 1'b0;
    case (state)
      IDLE: begin
        s_axis_y_tready = 1'b1;
        if (s_axis_y_tvalid) begin
          state_nx = SEND;
        end
      end
      SEND: begin
        m_axis_b_tvalid = 1'b1;
        if (m_axis_b_tready && (k_q == K_LAST)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame shift register, byte counter and registered output byte/tlast.
  // The frame shifts down one byte per handshake so the next byte is
  // always in the low bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_q <= '0;
      k_q     <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_hs) begin
      frame_q <= sext_frame;
      k_q     <= '0;
      data_q  <= sext_frame[7:0];
      last_q  <= (N_BYTES == 1);
    end else if (out_hs) begin
      if (k_q != K_LAST) begin
        k_q     <= k_inc;
        frame_q <= frame_sh;
        data_q  <= next_byte;
        last_q  <= (k_inc == K_LAST);
      end else begin
        last_q  <= 1'b0;
      end
    end
  end

  assign m_axis_b_tdata = data_q;
  assign m_axis_b_tlast = last_q;

endmodule

// File: tb/tb_axis_y_byte_serializer.sv
// Bench for axis_y_byte_serializer. Build with Y_CHECKSUM_EN defined on both
// bench and RTL to exercise the checksum byte.
module tb_axis_y_byte_serializer;

  localparam int R       = 8;
  localparam int W_Y     = 19;
  localparam int W_Y_OUT = 32;
  localparam int N_DATA  = R * W_Y_OUT / 8;
`ifdef Y_CHECKSUM_EN
  localparam int N_BYTES = N_DATA + 1;
`else
  localparam int N_BYTES = N_DATA;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic               s_tvalid;
  logic               s_tready;
  logic [R*W_Y-1:0]   s_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic [7:0]         m_tdata;
  logic               m_tlast;

  axis_y_byte_serializer #(
    .R(R), .W_Y(W_Y), .W_Y_OUT(W_Y_OUT), .BITS_PER_WORD(8)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .s_axis_y_tvalid (s_tvalid),
    .s_axis_y_tready (s_tready),
    .s_axis_y_tdata  (s_tdata),
    .m_axis_b_tvalid (m_tvalid),
    .m_axis_b_tready (m_tready),
    .m_axis_b_tdata  (m_tdata),
    .m_axis_b_tlast  (m_tlast)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {tlast, byte}
  int checks   = 0;
  int failures = 0;
  logic [7:0] got [0:127];

  // Reference model: sign-extend bit by bit, then split into bytes LSB first.
  function automatic void push_frame(input logic [R*W_Y-1:0] w);
    logic [W_Y_OUT-1:0] e;
    logic [7:0] b;
    logic [7:0] cs;
    int n;
    cs = 8'h00;
    n  = 0;
    for (int r = 0; r < R; r++) begin
      for (int i = 0; i < W_Y_OUT; i++) begin
        e[i] = (i < W_Y) ? w[W_Y*r + i] : w[W_Y*r + W_Y - 1];
      end
      for (int j = 0; j < W_Y_OUT/8; j++) begin
        b  = e[8*j +: 8];
        cs = cs ^ b;
        n++;
        exp_q.push_back({(n == N_BYTES), b});
      end
    end
`ifdef Y_CHECKSUM_EN
    exp_q.push_back({1'b1, cs});
`endif
  endfunction

  function automatic logic [R*W_Y-1:0] rand_word();
    logic [R*W_Y-1:0] w;
    for (int r = 0; r < R; r++) w[W_Y*r +: W_Y] = W_Y'($urandom);
    return w;
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge; offers a word until accepted.
  task automatic offer_word(input logic [R*W_Y-1:0] w);
    int g;
    s_tvalid = 1'b1;
    s_tdata  = w;
    push_frame(w);
    g = 0;
    while (!s_tready && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_tready, m_tvalid, m_tdata, m_tlast} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset: got rdy=%0b vld=%0b data=%h last=%0b, want 1 0 00 0",
               s_tready, m_tvalid, m_tdata, m_tlast);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sign_ext();
    logic [R*W_Y-1:0] w;
    logic [8:0] e;
    int idx, g;
    w = '0;
    w[W_Y-1:0] = 19'h7FFFF;
    m_tready = 1'b1;
    offer_word(w);
    checks++;
    if (m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL sext_latency: got tvalid=%0b one cycle after accept, want 1", m_tvalid);
    end
    idx = 0; g = 0;
    while (exp_q.size() > 0 && g < 200) begin
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        checks++;
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL sext byte %0d: got last=%0b data=%h, want last=%0b data=%h",
                   idx, m_tlast, m_tdata, e[8], e[7:0]);
        end
        got[idx] = m_tdata;
        idx++;
      end
      @(negedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() != 0 || got[0] !== 8'hFF || got[3] !== 8'hFF || got[4] !== 8'h00) begin
      failures++;
      $display("FAIL sext_bytes: left=%0d b0=%h b3=%h b4=%h, want 0 ff ff 00",
               exp_q.size(), got[0], got[3], got[4]);
      exp_q.delete();
    end
    checks++;
    if ({s_tready, m_tvalid, m_tlast} !== 3'b100) begin
      failures++;
      $display("FAIL sext_idle: got rdy=%0b vld=%0b last=%0b, want 1 0 0", s_tready, m_tvalid, m_tlast);
    end
  endtask

  task automatic test_byte_order();
    logic [R*W_Y-1:0] w;
    logic [8:0] e;
    int idx, g;
    w = '0;
    w[W_Y*0 +: W_Y] = 19'h00123;
    w[W_Y*7 +: W_Y] = 19'h3FFFF;
    m_tready = 1'b1;
    offer_word(w);
    idx = 0; g = 0;
    while (exp_q.size() > 0 && g < 200) begin
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        checks++;
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL order byte %0d: got last=%0b data=%h, want last=%0b data=%h",
                   idx, m_tlast, m_tdata, e[8], e[7:0]);
        end
        got[idx] = m_tdata;
        idx++;
      end
      @(negedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() != 0 || {got[0], got[1], got[28], got[29], got[30], got[31]} !== 48'h2301FFFF0300) begin
      failures++;
      $display("FAIL order_bytes: left=%0d got %h %h %h %h %h %h, want 23 01 ff ff 03 00",
               exp_q.size(), got[0], got[1], got[28], got[29], got[30], got[31]);
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    logic [7:0] hold_d;
    logic hold_l;
    int idx, g;
    m_tready = 1'b1;
    offer_word(rand_word());
    idx = 0; g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      if (idx == 3 && g < 100) begin
        // Stall on byte 3 for five cycles.
        m_tready = 1'b0;
        hold_d = m_tdata;
        hold_l = m_tlast;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if ({m_tvalid, m_tdata, m_tlast, s_tready} !== {1'b1, hold_d, hold_l, 1'b0}) begin
            failures++;
            $display("FAIL backpressure: got vld=%0b data=%h last=%0b rdy=%0b, want 1 %h %0b 0",
                     m_tvalid, m_tdata, m_tlast, s_tready, hold_d, hold_l);
          end
        end
        m_tready = 1'b1;
        g = 100;
      end
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        checks++;
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL bp byte %0d: got last=%0b data=%h, want last=%0b data=%h",
                   idx, m_tlast, m_tdata, e[8], e[7:0]);
        end
        idx++;
      end
      @(negedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_timeout: got %0d bytes left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [R*W_Y-1:0] wa, wb;
    logic [8:0] e;
    int g, gap, last_cyc, acc_cyc;
    bit seen_last, b_acc;
    wa = rand_word();
    wb = ~wa;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = wa;
    push_frame(wa);
    @(negedge clk);      // A accepted on the edge just passed
    s_tdata = wb;
    push_frame(wb);
    g = 0; gap = 0; last_cyc = -1; acc_cyc = -1; seen_last = 0; b_acc = 0;
    while (exp_q.size() > 0 && g < 300) begin
      if (m_tvalid) begin
        e = exp_q.pop_front();
        checks++;
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL b2b byte: got last=%0b data=%h, want last=%0b data=%h",
                   m_tlast, m_tdata, e[8], e[7:0]);
        end
        if (m_tlast && !seen_last) begin
          seen_last = 1;
          last_cyc  = g;
        end
      end else if (seen_last) begin
        gap++;
      end
      if (s_tvalid && s_tready && !b_acc) begin
        b_acc   = 1;
        acc_cyc = g;
      end
      @(negedge clk);
      g++;
      if (b_acc) s_tvalid = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0 || gap != 1 || acc_cyc != last_cyc + 1) begin
      failures++;
      $display("FAIL b2b_timing: got left=%0d gap=%0d accept_ofs=%0d, want 0 1 1",
               exp_q.size(), gap, acc_cyc - last_cyc);
      exp_q.delete();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] e;
    int idx, g;
    m_tready = 1'b1;
    offer_word(rand_word());
    idx = 0; g = 0;
    while (idx < 10 && g < 100) begin
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        idx++;
      end
      @(negedge clk);
      g++;
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({s_tready, m_tvalid, m_tdata, m_tlast} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: got rdy=%0b vld=%0b data=%h last=%0b, want 1 0 00 0",
               s_tready, m_tvalid, m_tdata, m_tlast);
    end
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_ready: got %0b, want 1", s_tready);
    end
    offer_word(rand_word());
    idx = 0; g = 0;
    while (exp_q.size() > 0 && g < 200) begin
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        checks++;
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL restart byte %0d: got last=%0b data=%h, want last=%0b data=%h",
                   idx, m_tlast, m_tdata, e[8], e[7:0]);
        end
        idx++;
      end
      @(negedge clk);
      g++;
    end
  endtask

  task automatic test_random_stall();
    logic [8:0] e;
    int g;
    for (int f = 0; f < 4; f++) begin
      m_tready = 1'b1;
      offer_word(rand_word());
      g = 0;
      while (exp_q.size() > 0 && g < 400) begin
        m_tready = ($urandom_range(0, 2) != 0);
        if (m_tvalid && m_tready) begin
          e = exp_q.pop_front();
          checks++;
          if ({m_tlast, m_tdata} !== e) begin
            failures++;
            $display("FAIL random frame %0d: got last=%0b data=%h, want last=%0b data=%h",
                     f, m_tlast, m_tdata, e[8], e[7:0]);
          end
        end
        @(negedge clk);
        g++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL random_timeout frame %0d: %0d bytes left, want 0", f, exp_q.size());
        exp_q.delete();
      end
      @(negedge clk);
    end
    m_tready = 1'b1;
  endtask

`ifdef Y_CHECKSUM_EN
  task automatic test_checksum();
    logic [R*W_Y-1:0] w;
    logic [8:0] e;
    int idx, g;
    logic [8:0] b31, b32;
    w = '0;
    w[W_Y-1:0] = 19'h00123;
    m_tready = 1'b1;
    offer_word(w);
    idx = 0; g = 0; b31 = '0; b32 = '0;
    while (exp_q.size() > 0 && g < 200) begin
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        checks++;
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL csum byte %0d: got last=%0b data=%h, want last=%0b data=%h",
                   idx, m_tlast, m_tdata, e[8], e[7:0]);
        end
        if (idx == 31) b31 = {m_tlast, m_tdata};
        if (idx == 32) b32 = {m_tlast, m_tdata};
        idx++;
      end
      @(negedge clk);
      g++;
    end
    checks++;
    if (idx != 33 || b31 !== 9'h000 || b32 !== 9'h122) begin
      failures++;
      $display("FAIL csum_frame: got n=%0d b31=%h b32=%h, want 33 000 122", idx, b31, b32);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sign_ext();
    test_byte_order();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_stall();
`ifdef Y_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
